// File: rtl/scu_pkg.sv
// Shared definitions for the decode/issue stage: instruction field layout,
// opcode values and the per-opcode control decode.
package scu_pkg;

    localparam int REG_AW   = 6;
    localparam int NUM_REGS = 64;
    localparam int INSTR_W  = 32;

    localparam int OPC_HI = 31;
    localparam int OPC_LO = 28;
    localparam int RD_HI  = 27;
    localparam int RD_LO  = 22;
    localparam int RS_HI  = 21;
    localparam int RS_LO  = 16;
    localparam int RT_HI  = 15;
    localparam int RT_LO  = 10;

    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_ST   = 4'h3;
    localparam logic [3:0] OP_ADD  = 4'h4;
    localparam logic [3:0] OP_INC  = 4'h5;
    localparam logic [3:0] OP_NEG  = 4'h6;
    localparam logic [3:0] OP_SUB  = 4'h7;
    localparam logic [3:0] OP_J    = 4'h8;
    localparam logic [3:0] OP_BRZ  = 4'h9;
    localparam logic [3:0] OP_JM   = 4'hA;
    localparam logic [3:0] OP_BRN  = 4'hB;
    localparam logic [3:0] OP_LD   = 4'hE;
    localparam logic [3:0] OP_SVPC = 4'hF;

    typedef struct packed {
        logic use_rs;
        logic use_rt;
        logic regwrite;
        logic memread;
        logic memwrite;
        logic jump;
        logic brz;
        logic brn;
    } ctrl_t;

    // Unlisted opcodes fall through to the all-zero (NOP) control word.
    function automatic ctrl_t decode_op(input logic [3:0] op);
        ctrl_t c;
        c = '0;
        case (op)
            OP_ST:          begin c.use_rs = 1'b1; c.use_rt = 1'b1; c.memwrite = 1'b1; end
            OP_ADD, OP_SUB: begin c.use_rs = 1'b1; c.use_rt = 1'b1; c.regwrite = 1'b1; end
            OP_INC, OP_NEG: begin c.use_rs = 1'b1; c.regwrite = 1'b1; end
            OP_LD:          begin c.use_rs = 1'b1; c.regwrite = 1'b1; c.memread = 1'b1; end
            OP_J:           begin c.use_rs = 1'b1; c.jump = 1'b1; end
            OP_BRZ:         begin c.use_rs = 1'b1; c.brz = 1'b1; end
            OP_BRN:         begin c.use_rs = 1'b1; c.brn = 1'b1; end
            OP_JM:          begin c.use_rs = 1'b1; c.memread = 1'b1; c.jump = 1'b1; end
            OP_SVPC:        begin c.regwrite = 1'b1; end
            default:        c = '0;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/scu_scoreboard.sv
// Pending-write scoreboard: one busy bit per register plus an outstanding
// write counter, with same-cycle writeback bypass on the hazard query.
module scu_scoreboard
    import scu_pkg::*;
#(
    parameter int MAX_PENDING = 8
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [REG_AW-1:0] q_rs,
    input  logic [REG_AW-1:0] q_rt,
    input  logic [REG_AW-1:0] q_rd,
    input  logic              q_use_rs,
    input  logic              q_use_rt,
    input  logic              q_use_rd,
    output logic              hazard,
    input  logic              set_en,
    input  logic [REG_AW-1:0] set_rd,
    input  logic              wb_valid,
    input  logic [REG_AW-1:0] wb_rd
);

    localparam int CNT_W = $clog2(MAX_PENDING + 1);

    logic [NUM_REGS-1:0] busy_q, busy_d;
    logic [NUM_REGS-1:0] wb_mask, busy_eff;
    logic [CNT_W-1:0]    pend_cnt_q, pend_cnt_d;
    logic                clr_en, pend_full;

    always_comb begin
        wb_mask = '0;
        if (wb_valid) wb_mask[wb_rd] = 1'b1;
        busy_eff  = busy_q & ~wb_mask;
        pend_full = (pend_cnt_q == CNT_W'(MAX_PENDING));

        hazard = (q_use_rs && busy_eff[q_rs]) ||
                 (q_use_rt && busy_eff[q_rt]) ||
                 (q_use_rd && (busy_eff[q_rd] || pend_full));

        // A writeback to a register that is not pending is ignored entirely.
        clr_en = wb_valid && busy_q[wb_rd];

        busy_d = busy_q;
        if (clr_en) busy_d[wb_rd]  = 1'b0;
        if (set_en) busy_d[set_rd] = 1'b1;

        pend_cnt_d = pend_cnt_q;
        if (set_en && !clr_en && !pend_full)
            pend_cnt_d = pend_cnt_q + CNT_W'(1);
        else if (clr_en && !set_en && (pend_cnt_q != '0))
            pend_cnt_d = pend_cnt_q - CNT_W'(1);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            busy_q     <= '0;
            pend_cnt_q <= '0;
        end else begin
            busy_q     <= busy_d;
            pend_cnt_q <= pend_cnt_d;
        end
    end

endmodule

// File: rtl/scu_decode_issue.sv
// Decode/issue stage: one-entry holding register, hazard-gated issue through
// an output register to execute, register-file read addresses from the hold.
module scu_decode_issue
    import scu_pkg::*;
#(
    parameter int MAX_PENDING = 8,
    parameter int PC_W        = 32
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       in_instr,
    input  logic [PC_W-1:0]   in_pc,
    input  logic              flush,
    input  logic              wb_valid,
    input  logic [5:0]        wb_rd,
    output logic [5:0]        rf_rs_addr,
    output logic [5:0]        rf_rt_addr,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [3:0]        out_opcode,
    output logic [5:0]        out_rd,
    output logic [5:0]        out_rs,
    output logic [5:0]        out_rt,
    output logic [5:0]        out_imm,
    output logic [PC_W-1:0]   out_pc,
    output logic              out_regwrite,
    output logic              out_memread,
    output logic              out_memwrite,
    output logic              out_jump,
    output logic              out_brz,
    output logic              out_brn
);

    // Only the opcode and register fields are kept; the low bits carry nothing we use.
    logic [OPC_HI:RT_LO] hold_instr_q, hold_instr_d;
    logic [PC_W-1:0]     hold_pc_q, hold_pc_d;
    logic                hold_valid_q, hold_valid_d;

    logic                out_valid_q, out_valid_d;
    logic [3:0]          out_opcode_q, out_opcode_d;
    logic [5:0]          out_rd_q, out_rd_d;
    logic [5:0]          out_rs_q, out_rs_d;
    logic [5:0]          out_rt_q, out_rt_d;
    logic [PC_W-1:0]     out_pc_q, out_pc_d;
    logic [5:0]          out_flags_q, out_flags_d;

    logic [3:0]          h_op;
    logic [REG_AW-1:0]   h_rd, h_rs, h_rt;
    ctrl_t               h_ctrl;
    logic                hazard, issue, accept;
    logic                unused_instr_bits;

    assign unused_instr_bits = ^in_instr[RT_LO-1:0];

    assign h_op   = hold_instr_q[OPC_HI:OPC_LO];
    assign h_rd   = hold_instr_q[RD_HI:RD_LO];
    assign h_rs   = hold_instr_q[RS_HI:RS_LO];
    assign h_rt   = hold_instr_q[RT_HI:RT_LO];
    assign h_ctrl = decode_op(h_op);

    scu_scoreboard #(
        .MAX_PENDING (MAX_PENDING)
    ) u_sb (
        .clock    (clock),
        .reset    (reset),
        .q_rs     (h_rs),
        .q_rt     (h_rt),
        .q_rd     (h_rd),
        .q_use_rs (h_ctrl.use_rs),
        .q_use_rt (h_ctrl.use_rt),
        .q_use_rd (h_ctrl.regwrite),
        .hazard   (hazard),
        .set_en   (issue && h_ctrl.regwrite),
        .set_rd   (h_rd),
        .wb_valid (wb_valid),
        .wb_rd    (wb_rd)
    );

    always_comb begin
        issue    = hold_valid_q && !hazard && !flush && (!out_valid_q || out_ready);
        in_ready = !flush && (!hold_valid_q || issue);
        accept   = in_valid && in_ready;

        rf_rs_addr = hold_valid_q ? h_rs : '0;
        rf_rt_addr = hold_valid_q ? h_rt : '0;

        hold_valid_d = hold_valid_q;
        hold_instr_d = hold_instr_q;
        hold_pc_d    = hold_pc_q;
        if (flush) begin
            hold_valid_d = 1'b0;
        end else if (accept) begin
            hold_valid_d = 1'b1;
            hold_instr_d = in_instr[OPC_HI:RT_LO];
            hold_pc_d    = in_pc;
        end else if (issue) begin
            hold_valid_d = 1'b0;
        end

        out_valid_d  = out_valid_q;
        out_opcode_d = out_opcode_q;
        out_rd_d     = out_rd_q;
        out_rs_d     = out_rs_q;
        out_rt_d     = out_rt_q;
        out_pc_d     = out_pc_q;
        out_flags_d  = out_flags_q;
        if (flush) begin
            out_valid_d = 1'b0;
        end else if (issue) begin
            out_valid_d  = 1'b1;
            out_opcode_d = h_op;
            out_rd_d     = h_rd;
            out_rs_d     = h_rs;
            out_rt_d     = h_rt;
            out_pc_d     = hold_pc_q;
            out_flags_d  = {h_ctrl.regwrite, h_ctrl.memread, h_ctrl.memwrite,
                            h_ctrl.jump, h_ctrl.brz, h_ctrl.brn};
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            hold_valid_q <= 1'b0;
            hold_instr_q <= '0;
            hold_pc_q    <= '0;
            out_valid_q  <= 1'b0;
            out_opcode_q <= '0;
            out_rd_q     <= '0;
            out_rs_q     <= '0;
            out_rt_q     <= '0;
            out_pc_q     <= '0;
            out_flags_q  <= '0;
        end else begin
            hold_valid_q <= hold_valid_d;
            hold_instr_q <= hold_instr_d;
            hold_pc_q    <= hold_pc_d;
            out_valid_q  <= out_valid_d;
            out_opcode_q <= out_opcode_d;
            out_rd_q     <= out_rd_d;
            out_rs_q     <= out_rs_d;
            out_rt_q     <= out_rt_d;
            out_pc_q     <= out_pc_d;
            out_flags_q  <= out_flags_d;
        end
    end

    // Immediate and rt share bits [15:10].
    assign out_valid  = out_valid_q;
    assign out_opcode = out_opcode_q;
    assign out_rd     = out_rd_q;
    assign out_rs     = out_rs_q;
    assign out_rt     = out_rt_q;
    assign out_imm    = out_rt_q;
    assign out_pc     = out_pc_q;
    assign {out_regwrite, out_memread, out_memwrite, out_jump, out_brz, out_brn} = out_flags_q;

endmodule

// File: tb/tb_scu_decode_issue.sv
// Bench for scu_decode_issue: directed scenarios plus random traffic, all
// checked each cycle against a behavioural model of the stage.
module tb_scu_decode_issue;

    localparam int MAXP = 2;
    localparam int PC_W = 32;

    localparam logic [31:0] I_ADD  = 32'h40C10800;  // ADD x3,x1,x2
    localparam logic [31:0] I_SUB  = 32'h71030400;  // SUB x4,x3,x1
    localparam logic [31:0] I_ST   = 32'h30010800;  // ST  rs=x1, rt=x2
    localparam logic [31:0] I_INC5 = 32'h51400000;
    localparam logic [31:0] I_INC6 = 32'h51800000;
    localparam logic [31:0] I_INC7 = 32'h51C00000;

    logic            clock = 1'b0;
    logic            reset;
    logic            in_valid, in_ready, flush, wb_valid, out_valid, out_ready;
    logic [31:0]     in_instr;
    logic [PC_W-1:0] in_pc, out_pc;
    logic [5:0]      wb_rd, rf_rs_addr, rf_rt_addr, out_rd, out_rs, out_rt, out_imm;
    logic [3:0]      out_opcode;
    logic            out_regwrite, out_memread, out_memwrite, out_jump, out_brz, out_brn;

    always #5 clock = ~clock;

    scu_decode_issue #(.MAX_PENDING(MAXP), .PC_W(PC_W)) dut (
        .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_instr(in_instr), .in_pc(in_pc), .flush(flush), .wb_valid(wb_valid),
        .wb_rd(wb_rd), .rf_rs_addr(rf_rs_addr), .rf_rt_addr(rf_rt_addr),
        .out_valid(out_valid), .out_ready(out_ready), .out_opcode(out_opcode),
        .out_rd(out_rd), .out_rs(out_rs), .out_rt(out_rt), .out_imm(out_imm),
        .out_pc(out_pc), .out_regwrite(out_regwrite), .out_memread(out_memread),
        .out_memwrite(out_memwrite), .out_jump(out_jump), .out_brz(out_brz),
        .out_brn(out_brn)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic            m_hold_v, m_out_v;
    logic [31:0]     m_hold_i;
    logic [PC_W-1:0] m_hold_pc, m_out_pc;
    logic [33:0]     m_out_f;
    logic [63:0]     m_busy;
    int              m_pend;
    logic [31:0]     pc_ctr = 32'h1000;

    // Per-opcode behaviour: {reads rs, reads rt, writes rd, memread, memwrite, jump, brz, brn}
    function automatic logic [7:0] op_info(input logic [3:0] op);
        case (op)
            4'h3:       return 8'hC8;
            4'h4, 4'h7: return 8'hE0;
            4'h5, 4'h6: return 8'hA0;
            4'hE:       return 8'hB0;
            4'h8:       return 8'h84;
            4'h9:       return 8'h82;
            4'hB:       return 8'h81;
            4'hA:       return 8'h94;
            4'hF:       return 8'h20;
            default:    return 8'h00;
        endcase
    endfunction

    task automatic model_reset();
        m_hold_v = 0; m_out_v = 0; m_hold_i = 0; m_hold_pc = 0;
        m_out_pc = 0; m_out_f = 0; m_busy = 0; m_pend = 0;
    endtask

    // One clock cycle: drive at negedge, compare just after, advance the model.
    task automatic cycle(input logic iv, input logic [31:0] ins, input logic [31:0] pc,
                         input logic fl, input logic ordy, input logic wv,
                         input logic [5:0] wr, output logic acc);
        logic [7:0]  info;
        logic [5:0]  rd, rs, rt;
        logic [63:0] eff;
        logic        haz, iss, rdy;
        @(negedge clock);
        in_valid = iv; in_instr = ins; in_pc = pc; flush = fl;
        out_ready = ordy; wb_valid = wv; wb_rd = wr;
        #1;
        info = op_info(m_hold_i[31:28]);
        rd = m_hold_i[27:22]; rs = m_hold_i[21:16]; rt = m_hold_i[15:10];
        eff = m_busy;
        if (wv) eff[wr] = 1'b0;
        haz = (info[7] && eff[rs]) || (info[6] && eff[rt]) ||
              (info[5] && (eff[rd] || m_pend == MAXP));
        iss = m_hold_v && !haz && !fl && (!m_out_v || ordy);
        rdy = !fl && (!m_hold_v || iss);

        check_eq("in_ready", in_ready, rdy);
        check_eq("out_valid", out_valid, m_out_v);
        check_eq("rf_rs_addr", rf_rs_addr, m_hold_v ? rs : 6'd0);
        check_eq("rf_rt_addr", rf_rt_addr, m_hold_v ? rt : 6'd0);
        if (m_out_v) begin
            check_eq("out_fields", {out_opcode, out_rd, out_rs, out_rt, out_imm, out_regwrite,
                     out_memread, out_memwrite, out_jump, out_brz, out_brn}, m_out_f);
            check_eq("out_pc", out_pc, m_out_pc);
        end
        check_eq("scoreboard", dut.u_sb.busy_q, m_busy);
        check_eq("pend_cnt", 64'(dut.u_sb.pend_cnt_q), 64'(m_pend));

        if (wv && m_busy[wr]) begin m_busy[wr] = 1'b0; m_pend--; end
        if (iss && info[5])   begin m_busy[rd] = 1'b1; m_pend++; end
        if (fl) m_out_v = 0;
        else if (iss) begin
            m_out_v = 1; m_out_f = {m_hold_i[31:28], rd, rs, rt, rt, info[5:0]};
            m_out_pc = m_hold_pc;
        end else if (ordy) m_out_v = 0;
        acc = iv && rdy;
        if (fl) m_hold_v = 0;
        else if (acc) begin m_hold_v = 1; m_hold_i = ins; m_hold_pc = pc; end
        else if (iss) m_hold_v = 0;
    endtask

    task automatic idle(input logic ordy, input logic wv, input logic [5:0] wr);
        logic acc;
        cycle(1'b0, 32'h0, 32'h0, 1'b0, ordy, wv, wr, acc);
    endtask

    task automatic send(input logic [31:0] ins, input logic ordy);
        logic acc;
        int   n;
        acc = 0; n = 0;
        while (!acc && n < 40) begin
            cycle(1'b1, ins, pc_ctr, 1'b0, ordy, 1'b0, 6'd0, acc);
            n++;
        end
        pc_ctr += 4;
        check_eq("send_accepted", acc, 1'b1);
    endtask

    initial begin
        logic acc;
        reset = 1; in_valid = 0; in_instr = 0; in_pc = 0; flush = 0;
        out_ready = 0; wb_valid = 0; wb_rd = 0;
        model_reset();
        #1;
        check_eq("rst_in_ready", in_ready, 1'b1);
        check_eq("rst_out_valid", out_valid, 1'b0);
        check_eq("rst_out_data", {out_opcode, out_rd, out_rs, out_rt, out_pc}, 0);
        check_eq("rst_pend", 64'(dut.u_sb.pend_cnt_q), 0);
        @(negedge clock); @(negedge clock);
        reset = 0;

        // ADD issue latency and decode
        cycle(1'b1, I_ADD, 32'h100, 1'b0, 1'b1, 1'b0, 6'd0, acc);
        check_eq("add_accept", acc, 1'b1);
        idle(1'b1, 1'b0, 6'd0);
        check_eq("add_rf_rs", rf_rs_addr, 6'd1);
        check_eq("add_rf_rt", rf_rt_addr, 6'd2);
        check_eq("add_not_yet_valid", out_valid, 1'b0);
        cycle(1'b1, I_SUB, 32'h104, 1'b0, 1'b1, 1'b0, 6'd0, acc);
        check_eq("add_out_valid", out_valid, 1'b1);
        check_eq("add_decode", {out_opcode, out_rd, out_rs, out_rt, out_regwrite},
                 {4'd4, 6'd3, 6'd1, 6'd2, 1'b1});
        check_eq("add_sb3", dut.u_sb.busy_q[3], 1'b1);
        check_eq("sub_accept", acc, 1'b1);

        // SUB stalls on x3 until writeback, then issues via bypass
        idle(1'b1, 1'b0, 6'd0);
        check_eq("sub_stall_ready", in_ready, 1'b0);
        check_eq("sub_stall_valid", out_valid, 1'b0);
        idle(1'b1, 1'b0, 6'd0);
        check_eq("sub_stall_ready2", in_ready, 1'b0);
        idle(1'b1, 1'b1, 6'd3);
        check_eq("sub_bypass_issue", in_ready, 1'b1);
        cycle(1'b1, I_ST, 32'h108, 1'b0, 1'b0, 1'b0, 6'd0, acc);
        check_eq("sub_out", {out_valid, out_opcode}, {1'b1, 4'd7});
        check_eq("sub_sb4", dut.u_sb.busy_q[4], 1'b1);
        check_eq("sub_sb3_clear", dut.u_sb.busy_q[3], 1'b0);

        // Backpressure: output stable, ST held, then both drain
        for (int i = 0; i < 5; i++) begin
            idle(1'b0, 1'b0, 6'd0);
            check_eq("bp_opcode", out_opcode, 4'd7);
            check_eq("bp_pc", out_pc, 32'h104);
            check_eq("bp_in_ready", in_ready, 1'b0);
            check_eq("bp_held_rs", rf_rs_addr, 6'd1);
        end
        idle(1'b1, 1'b0, 6'd0);
        check_eq("drain_issue", in_ready, 1'b1);
        idle(1'b1, 1'b0, 6'd0);
        check_eq("drain_st", {out_valid, out_opcode, out_memwrite}, {1'b1, 4'd3, 1'b1});
        idle(1'b1, 1'b1, 6'd4);
        check_eq("drain_done", out_valid, 1'b0);

        // Pending-write limit (MAX_PENDING = 2)
        send(I_INC5, 1'b1);
        send(I_INC6, 1'b1);
        send(I_INC7, 1'b1);
        for (int i = 0; i < 3; i++) idle(1'b1, 1'b0, 6'd0);
        check_eq("lim_pend", 64'(dut.u_sb.pend_cnt_q), 2);
        check_eq("lim_stall", in_ready, 1'b0);
        check_eq("lim_sb7", dut.u_sb.busy_q[7], 1'b0);
        idle(1'b1, 1'b1, 6'd5);
        idle(1'b1, 1'b0, 6'd0);
        check_eq("lim_issue", in_ready, 1'b1);
        idle(1'b1, 1'b0, 6'd0);
        check_eq("lim_pend_back", 64'(dut.u_sb.pend_cnt_q), 2);
        check_eq("lim_sb7_set", dut.u_sb.busy_q[7], 1'b1);
        check_eq("lim_out", {out_valid, out_opcode, out_rd}, {1'b1, 4'd5, 6'd7});
        idle(1'b1, 1'b1, 6'd6);
        idle(1'b1, 1'b1, 6'd7);

        // Flush with hold and output both occupied
        send(I_ADD, 1'b0);
        send(32'h0, 1'b0);
        cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0, 6'd0, acc);
        check_eq("flush_in_ready", in_ready, 1'b0);
        idle(1'b0, 1'b0, 6'd0);
        check_eq("flush_out_valid", out_valid, 1'b0);
        check_eq("flush_hold_empty", in_ready, 1'b1);
        check_eq("flush_sb3_kept", dut.u_sb.busy_q[3], 1'b1);
        idle(1'b1, 1'b1, 6'd3);
        idle(1'b1, 1'b0, 6'd0);
        check_eq("flush_sb3_retired", dut.u_sb.busy_q[3], 1'b0);

        // Asynchronous reset in the middle of a stall
        send(I_ADD, 1'b1);
        send(I_SUB, 1'b1);
        idle(1'b1, 1'b0, 6'd0);
        idle(1'b1, 1'b0, 6'd0);
        check_eq("pre_rst_stall", in_ready, 1'b0);
        @(negedge clock);
        #3 reset = 1;
        #1;
        check_eq("arst_out_valid", out_valid, 1'b0);
        check_eq("arst_pend", 64'(dut.u_sb.pend_cnt_q), 0);
        check_eq("arst_sb", dut.u_sb.busy_q, 0);
        check_eq("arst_in_ready", in_ready, 1'b1);
        model_reset();
        @(negedge clock);
        reset = 0;

        // Random traffic on a small register window to provoke hazards
        for (int i = 0; i < 2000; i++) begin
            logic [31:0] ins;
            ins = {4'($urandom_range(0, 15)), 3'b0, 3'($urandom), 3'b0, 3'($urandom),
                   3'b0, 3'($urandom), 10'($urandom)};
            cycle(1'($urandom_range(0, 9) < 6), ins, $urandom, 1'($urandom_range(0, 19) == 0),
                  1'($urandom_range(0, 9) < 7), 1'($urandom_range(0, 9) < 3),
                  6'($urandom_range(0, 7)), acc);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/scu_decode_issue.md
Name: scu_decode_issue

Overview:
- Decode/issue stage between instruction fetch and the 64x32 register file read.
- Accepts instructions from fetch on a valid/ready handshake, decodes the opcode and register fields, and drives register-file read addresses.
- Tracks pending register writes in a 64-entry scoreboard and stalls on RAW/WAW hazards.
- Issues decoded control to execute through an output register.

Parameters:
MAX_PENDING, 8, maximum outstanding issued register writes (1..63)
PC_W, 32, program-counter width

Ports:
clock  in  1  rising-edge clock
reset  in  1  asynchronous, active-high reset
in_valid  in  1  fetch presents an instruction
in_ready  out  1  stage can accept this cycle
in_instr  in  32  instruction: [31:28] opcode, [27:22] rd, [21:16] rs, [15:10] rt/imm
in_pc  in  PC_W  PC of in_instr
flush  in  1  discard held and output instructions (taken branch)
wb_valid  in  1  writeback completing this cycle
wb_rd  in  6  destination being written back
rf_rs_addr  out  6  register-file read address A (rs of held instruction)
rf_rt_addr  out  6  register-file read address B (rt of held instruction)
out_valid  out  1  decoded instruction valid
out_ready  in  1  execute accepts
out_opcode  out  4  opcode
out_rd, out_rs, out_rt  out  6 each  register fields
out_imm  out  6  [15:10] zero-extended field
out_pc  out  PC_W  PC
out_regwrite, out_memread, out_memwrite, out_jump, out_brz, out_brn  out  1 each  control

Behaviour:
- Reset (async): hold_valid=0, out_valid=0, scoreboard=0, pend_cnt=0, all out_* data=0, in_ready=1.
- Opcodes:
  - NOP 0000: no reads/writes.
  - ST 0011: reads rs, rt; memwrite.
  - ADD 0100 / SUB 0111: read rs, rt; write rd.
  - INC 0101 / NEG 0110 / LD 1110: read rs; write rd. LD also memread.
  - J 1000 / BRZ 1001 / BRN 1011: read rs; jump/brz/brn.
  - JM 1010: read rs; memread, jump.
  - SVPC 1111: write rd, no reads.
  - Other opcodes decode as NOP.
- Holding register (1 entry):
  - in_ready = !hold_valid || issue.
  - Accept on in_valid && in_ready.
- rf_rs_addr/rf_rt_addr are combinational from the held instruction; 0 when hold empty.
- hazard (all terms gated by the operand/destination actually being used):
  - busy_eff[rs] set, or busy_eff[rt] set, or busy_eff[rd] set;
  - or pend_cnt==MAX_PENDING for a writing instruction.
  - busy_eff = scoreboard & ~(wb_valid ? onehot(wb_rd) : 0), i.e. same-cycle writeback bypass.
- issue = hold_valid && !hazard && !flush && (!out_valid || out_ready).
- Latency:
  - Accept at edge N → out_valid earliest after edge N+1.
  - Throughput 1/cycle with no hazards.
- Output register:
  - Loads on issue.
  - out_valid stays high until out_ready, then clears unless another issue occurs.
  - Data stable while out_valid && !out_ready.
- Scoreboard:
  - issue with regwrite sets bit rd and increments pend_cnt.
  - wb_valid clears bit wb_rd and decrements pend_cnt.
  - Same edge, same register: set wins, counter unchanged.
  - wb_valid on an already-clear bit: ignored, no decrement.
- flush:
  - Clears hold_valid and out_valid next edge; in_ready=0 that cycle.
  - Scoreboard and pend_cnt are NOT cleared; in-flight writes still retire.
- pend_cnt never exceeds MAX_PENDING or underflows.
- Reset mid-operation: all state cleared immediately, regardless of clock.

Decomposition:
- Package scu_pkg: opcode localparams (OP_NOP..OP_SVPC), field bit positions, REG_AW=6, NUM_REGS=64, decoded-control struct/typedef.
- Sub-module scu_scoreboard: busy vector, pend_cnt, set/clear/bypass and hazard query. Decoder logic and handshake stay in the top level.

Test Plan:
- Reset, then ADD x3,x1,x2 (0x40C10800), out_ready=1 → out_valid two edges after accept; out_opcode=4, rd=3, rs=1, rt=2, out_regwrite=1; rf_rs_addr=1 and rf_rt_addr=2 while held; scoreboard[3]=1.
- ADD 0x40C10800 followed by SUB x4,x3,x1 (0x71030400) → SUB stalls with out_valid=0 and in_ready=0. Assert wb_valid with wb_rd=3 → SUB issues that same cycle (bypass) and sets scoreboard[4].
- out_ready=0 while valid for 5 cycles → outputs held stable, second instruction held, in_ready=0. Release → both drain in consecutive cycles.
- MAX_PENDING=2: three INCs to x5, x6, x7 with no writebacks → third stalls. One wb to x5 → third issues; pend_cnt returns to 2.
- flush while hold and out both valid, scoreboard[3] set → out_valid=0 and hold empty next cycle; scoreboard[3] still 1 until wb_rd=3.
- Assert reset mid-stall (async, between edges) → out_valid, pend_cnt and scoreboard go to 0 immediately; in_ready=1.
